apb_decoder_n: RTL and testbench

Registered 1-to-N APB fabric that connects one APB master to `N_SLAVES` APB slaves. It decodes each transfer into equal-size address windows above `BASE_ADDR` and replays it on the selected downstream port. It returns the slave's response to the master one cycle after the slave completes. Unmapped addresses and (optionally) hung slaves are answered locally with `PSLVERR`. It sits between the CPU-side APB master and the peripheral APB slaves.

---
 rtl/apb_decoder_n.sv | 165 ++++++++++++++++
 tb/tb_apb_decoder_n.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_decoder_n.sv
// Registered 1-to-N APB fabric: decodes the upstream transfer into equal windows above BASE_ADDR
// and replays it on one downstream port. Optional hung-slave timeout via APB_DECODER_TIMEOUT_EN.
module apb_decoder_n #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    N_SLAVES        = 4,
    parameter int                    SLAVE_ADDR_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    TIMEOUT_CYCLES  = 255
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [ADDR_WIDTH-1:0]          s_PADDR,
    input  logic                           s_PSEL,
    input  logic                           s_PENABLE,
    input  logic                           s_PWRITE,
    input  logic [DATA_WIDTH-1:0]          s_PWDATA,
    output logic                           s_PREADY,
    output logic [DATA_WIDTH-1:0]          s_PRDATA,
    output logic                           s_PSLVERR,
    output logic [ADDR_WIDTH-1:0]          m_PADDR,
    output logic                           m_PWRITE,
    output logic [DATA_WIDTH-1:0]          m_PWDATA,
    output logic                           m_PENABLE,
    output logic [N_SLAVES-1:0]            m_PSEL,
    input  logic [N_SLAVES-1:0]            m_PREADY,
    input  logic [N_SLAVES-1:0]            m_PSLVERR,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] m_PRDATA
);

    localparam int                    IW    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [ADDR_WIDTH-1:0] NS_A  = ADDR_WIDTH'(N_SLAVES);
    localparam logic [N_SLAVES-1:0]   SEL_1 = N_SLAVES'(1);

    typedef enum logic [2:0] {IDLE, DSETUP, DACCESS, RESP, ERR} state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pslverr_q;
    logic                  abort_q;

    // Decode of the live upstream address; the compare against BASE_ADDR rules out wrap-around.
    logic [ADDR_WIDTH-1:0] offset, slot;
    logic                  mapped, capture;
    assign offset  = s_PADDR - BASE_ADDR;
    assign slot    = offset >> SLAVE_ADDR_BITS;
    assign mapped  = (s_PADDR >= BASE_ADDR) && (slot < NS_A);
    assign capture = (state_q == IDLE) && s_PSEL && !s_PENABLE;

    logic                  sel_rdy;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [N_SLAVES-1:0]   sel_oh;
    assign sel_rdy   = m_PREADY[idx_q];
    assign sel_rdata = m_PRDATA[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_oh    = SEL_1 << idx_q;

    logic to_hit;
`ifdef APB_DECODER_TIMEOUT_EN
    localparam logic [15:0] TO16 = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;

    // Counts stalled ACCESS cycles; the cycle that would make it reach the limit fires the timeout.
    assign to_hit = (state_q == DACCESS) && !sel_rdy && ((cnt_q + 16'd1) == TO16);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == DSETUP)
            cnt_d = '0;
        else if (state_q == DACCESS && !sel_rdy)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (capture) state_d = mapped ? DSETUP : ERR;
            DSETUP:  state_d = DACCESS;
            DACCESS: begin
                if (sel_rdy)     state_d = RESP;
                else if (to_hit) state_d = ERR;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A master that drops PSEL mid-transfer gets no PREADY; the downstream side still finishes.
    always_comb begin
        m_PSEL    = '0;
        m_PENABLE = 1'b0;
        s_PREADY  = 1'b0;
        s_PRDATA  = '0;
        s_PSLVERR = 1'b0;
        unique case (state_q)
            DSETUP:  m_PSEL = sel_oh;
            DACCESS: begin
                m_PSEL    = sel_oh;
                m_PENABLE = 1'b1;
            end
            RESP: if (!abort_q) begin
                s_PREADY  = 1'b1;
                s_PRDATA  = prdata_q;
                s_PSLVERR = pslverr_q;
            end
            ERR: if (!abort_q) begin
                s_PREADY  = 1'b1;
                s_PSLVERR = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            idx_q     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            if (capture) begin
                paddr_q  <= s_PADDR;
                pwrite_q <= s_PWRITE;
                pwdata_q <= s_PWDATA;
                idx_q    <= slot[IW-1:0];
                abort_q  <= 1'b0;
            end
            if ((state_q == DSETUP || state_q == DACCESS) && !s_PSEL)
                abort_q <= 1'b1;
            if (state_q == DACCESS && sel_rdy) begin
                prdata_q  <= sel_rdata;
                pslverr_q <= m_PSLVERR[idx_q];
            end
        end
    end

    assign m_PADDR  = paddr_q;
    assign m_PWRITE = pwrite_q;
    assign m_PWDATA = pwdata_q;

    a_sel_onehot: assert property (@(posedge PCLK) disable iff (!PRESETn) $onehot0(m_PSEL));
    a_rdy_single: assert property (@(posedge PCLK) disable iff (!PRESETn) s_PREADY |=> !s_PREADY);

endmodule

// File: tb/tb_apb_decoder_n.sv
// Bench for apb_decoder_n: directed vector table, randomized transfers against a decode model,
// plus abort, async-reset and (with APB_DECODER_TIMEOUT_EN) hung-slave sequences.
module tb_apb_decoder_n;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          N    = 4;
    localparam int          SAB  = 12;
    localparam logic [31:0] BASE = 32'h0;
`ifdef APB_DECODER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic            PCLK, PRESETn;
    logic [AW-1:0]   s_PADDR;
    logic            s_PSEL, s_PENABLE, s_PWRITE;
    logic [DW-1:0]   s_PWDATA;
    logic            s_PREADY, s_PSLVERR;
    logic [DW-1:0]   s_PRDATA;
    logic [AW-1:0]   m_PADDR;
    logic            m_PWRITE, m_PENABLE;
    logic [DW-1:0]   m_PWDATA;
    logic [N-1:0]    m_PSEL, m_PREADY, m_PSLVERR;
    logic [N*DW-1:0] m_PRDATA;

    apb_decoder_n #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_SLAVES(N), .SLAVE_ADDR_BITS(SAB),
                    .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .s_PADDR(s_PADDR), .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
        .s_PWDATA(s_PWDATA), .s_PREADY(s_PREADY), .s_PRDATA(s_PRDATA), .s_PSLVERR(s_PSLVERR),
        .m_PADDR(m_PADDR), .m_PWRITE(m_PWRITE), .m_PWDATA(m_PWDATA), .m_PENABLE(m_PENABLE),
        .m_PSEL(m_PSEL), .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR), .m_PRDATA(m_PRDATA));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Behavioural slaves: each waits wcfg[i] ACCESS cycles, or forever when hung.
    int          wcfg [N];
    bit          hang [N];
    bit          ecfg [N];
    logic [31:0] rcfg [N];
    int          acc_cnt = 0;

    always @(posedge PCLK)
        acc_cnt <= (m_PENABLE && m_PSEL != 0 && (m_PSEL & m_PREADY) == 0) ? acc_cnt + 1 : 0;

    always_comb begin
        m_PREADY  = '0;
        m_PSLVERR = '0;
        m_PRDATA  = '0;
        for (int i = 0; i < N; i++) begin
            m_PREADY[i]          = m_PSEL[i] && m_PENABLE && !hang[i] && (acc_cnt >= wcfg[i]);
            m_PSLVERR[i]         = ecfg[i];
            m_PRDATA[i*DW +: DW] = rcfg[i];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  sel;
    } dn_t;
    dn_t  dq[$];
    int   sel_cycles = 0, dacc_cycles = 0, oh_viol = 0, rdy_viol = 0;
    logic prev_rdy = 1'b0;

    always @(negedge PCLK) begin
        if (m_PENABLE && (m_PSEL & m_PREADY) != 0) dq.push_back('{m_PADDR, m_PWRITE, m_PWDATA, m_PSEL});
        if (m_PSEL != 0) sel_cycles <= sel_cycles + 1;
        if (m_PSEL != 0 && m_PENABLE) dacc_cycles <= dacc_cycles + 1;
        if ($countones(m_PSEL) > 1) oh_viol <= oh_viol + 1;
        if (prev_rdy && s_PREADY) rdy_viol <= rdy_viol + 1;
        prev_rdy <= s_PREADY;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
        s_PSEL = 1'b0; s_PENABLE = 1'b0;
    endtask

    // Returns right after the PREADY cycle so a following call starts back-to-back.
    task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err, output int lat);
        @(posedge PCLK); #1;
        s_PSEL = 1'b1; s_PENABLE = 1'b0; s_PADDR = a; s_PWRITE = w; s_PWDATA = wd;
        @(posedge PCLK); #1;
        s_PENABLE = 1'b1;
        lat = 1;
        while (!s_PREADY && lat < 200) begin
            @(posedge PCLK); #1;
            lat++;
        end
        rd  = s_PRDATA;
        err = s_PSLVERR;
    endtask

    task automatic check_dn(input string nm, input logic [31:0] a, input bit w,
                            input logic [31:0] wd, input logic [3:0] sel);
        dn_t d;
        if (dq.size() == 0) begin
            chk({nm, "_dn_count"}, 0, 1);
            return;
        end
        d = dq.pop_front();
        chk({nm, "_paddr"}, d.addr, a);
        chk({nm, "_psel"}, d.sel, sel);
        chk({nm, "_pwrite"}, d.wr, w);
        if (w) chk({nm, "_pwdata"}, d.wd, wd);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_m_psel"}, m_PSEL, 0);
        chk({nm, "_m_penable"}, m_PENABLE, 0);
        chk({nm, "_m_paddr"}, m_PADDR, 0);
        chk({nm, "_m_pwrite"}, m_PWRITE, 0);
        chk({nm, "_m_pwdata"}, m_PWDATA, 0);
        chk({nm, "_s_pready"}, s_PREADY, 0);
        chk({nm, "_s_prdata"}, s_PRDATA, 0);
        chk({nm, "_s_pslverr"}, s_PSLVERR, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wd;
        int          slv;
        int          wt;
        bit          serr;
        logic [31:0] rdat;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_sel;
    } vec_t;

    initial begin
        vec_t        vt[$];
        logic [31:0] rd;
        bit          err;
        int          lat, n0, s0;

        for (int i = 0; i < N; i++) begin
            wcfg[i] = 0; hang[i] = 0; ecfg[i] = 0; rcfg[i] = '0;
        end
        PRESETn = 1'b0;
        s_PSEL = 0; s_PENABLE = 0; s_PWRITE = 0; s_PADDR = '0; s_PWDATA = '0;
        #1;
        check_reset("por");
        repeat (3) @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1'b1;

        vt.push_back('{32'h0000_1004, 1, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,         3, 0, 32'h0,         4'b0010});
        vt.push_back('{32'h0000_3010, 0, 32'h0,         3, 2, 0, 32'h1234_5678, 5, 0, 32'h1234_5678, 4'b1000});
        vt.push_back('{32'h0000_4000, 0, 32'h0,        -1, 0, 0, 32'h0,         1, 1, 32'h0,         4'b0000});
        vt.push_back('{32'h0000_0000, 1, 32'h0000_00A5, 0, 0, 1, 32'h0,         3, 1, 32'h0,         4'b0001});
        vt.push_back('{32'h0000_2000, 1, 32'h0000_1111, 2, 0, 0, 32'h0,         3, 0, 32'h0,         4'b0100});
        vt.push_back('{32'h0000_0FFC, 0, 32'h0,         0, 1, 0, 32'hCAFE_F00D, 4, 0, 32'hCAFE_F00D, 4'b0001});
        vt.push_back('{32'h0000_3FFF, 0, 32'h0,         3, 0, 1, 32'h0BAD_F00D, 3, 1, 32'h0BAD_F00D, 4'b1000});
        vt.push_back('{32'hFFFF_FFFC, 0, 32'h0,        -1, 0, 0, 32'h0,         1, 1, 32'h0,         4'b0000});
        vt.push_back('{32'h0000_2004, 0, 32'h0,         2, 3, 0, 32'h5555_AAAA, 6, 0, 32'h5555_AAAA, 4'b0100});

        idle();
        foreach (vt[k]) begin
            if (vt[k].slv >= 0) begin
                wcfg[vt[k].slv] = vt[k].wt;
                ecfg[vt[k].slv] = vt[k].serr;
                rcfg[vt[k].slv] = vt[k].rdat;
            end
            s0 = sel_cycles;
            xfer(vt[k].addr, vt[k].wr, vt[k].wd, rd, err, lat);
            chk($sformatf("vec%0d_latency", k), lat, vt[k].exp_lat);
            chk($sformatf("vec%0d_pslverr", k), err, vt[k].exp_err);
            if (!vt[k].wr) chk($sformatf("vec%0d_prdata", k), rd, vt[k].exp_rd);
            if (vt[k].exp_sel != 0)
                check_dn($sformatf("vec%0d", k), vt[k].addr, vt[k].wr, vt[k].wd, vt[k].exp_sel);
            else begin
                chk($sformatf("vec%0d_no_psel", k), sel_cycles - s0, 0);
                chk($sformatf("vec%0d_no_dn", k), dq.size(), 0);
            end
        end
        idle();

        // Randomized transfers checked against the address-window model.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a, wd, rdat;
            bit          w, mapped, serr;
            int          s, wt;
            if ($urandom_range(0, 4) < 4)
                a = $urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC;
            else
                a = $urandom_range(32'h4000, 32'hFFFF_FFFF);
            w      = 1'($urandom_range(0, 1));
            wd     = $urandom;
            rdat   = $urandom;
            serr   = ($urandom_range(0, 3) == 0);
            wt     = $urandom_range(0, 3);
            mapped = (longint'(a) >= longint'(BASE)) && ((longint'(a) - longint'(BASE)) / (64'd1 << SAB) < N);
            s      = mapped ? int'((longint'(a) - longint'(BASE)) / (64'd1 << SAB)) : -1;
            if (mapped) begin
                wcfg[s] = wt; ecfg[s] = serr; rcfg[s] = rdat;
            end
            s0 = sel_cycles;
            xfer(a, w, wd, rd, err, lat);
            chk($sformatf("rnd%0d_latency", k), lat, mapped ? 3 + wt : 1);
            chk($sformatf("rnd%0d_pslverr", k), err, mapped ? serr : 1'b1);
            if (!w) chk($sformatf("rnd%0d_prdata", k), rd, mapped ? rdat : 32'h0);
            if (mapped) check_dn($sformatf("rnd%0d", k), a, w, wd, 4'(1 << s));
            else        chk($sformatf("rnd%0d_no_psel", k), sel_cycles - s0, 0);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();

        // Upstream abort: master drops PSEL during DSETUP.
        begin
            int rdy_seen = 0;
            wcfg[2] = 3; ecfg[2] = 0; rcfg[2] = 32'h0000_0077;
            n0 = dq.size();
            @(posedge PCLK); #1;
            s_PSEL = 1; s_PENABLE = 0; s_PADDR = 32'h2000; s_PWRITE = 0;
            @(posedge PCLK); #1;
            s_PSEL = 0;
            repeat (12) begin
                @(posedge PCLK); #1;
                if (s_PREADY) rdy_seen++;
            end
            chk("abort_no_pready", rdy_seen, 0);
            chk("abort_dn_completed", dq.size() - n0, 1);
            dq.delete();
            wcfg[2] = 0; rcfg[2] = 32'hA5A5_0001;
            xfer(32'h2000, 0, 32'h0, rd, err, lat);
            chk("post_abort_latency", lat, 3);
            chk("post_abort_prdata", rd, 32'hA5A5_0001);
            idle();
        end

        // Asynchronous reset while in DACCESS of a read to 0x1000.
        begin
            int guard = 0;
            wcfg[1] = 5; rcfg[1] = 32'h1111_2222;
            @(posedge PCLK); #1;
            s_PSEL = 1; s_PENABLE = 0; s_PADDR = 32'h1000; s_PWRITE = 0;
            @(posedge PCLK); #1;
            s_PENABLE = 1;
            while (!m_PENABLE && guard < 10) begin
                @(posedge PCLK); #1;
                guard++;
            end
            chk("rst_reached_access", m_PENABLE, 1);
            #2 PRESETn = 1'b0;
            #1;
            check_reset("async_rst");
            @(posedge PCLK); #1;
            s_PSEL = 0; s_PENABLE = 0;
            @(negedge PCLK) PRESETn = 1'b1;
            dq.delete();
            wcfg[1] = 0; rcfg[1] = 32'h0F0F_1234;
            xfer(32'h1000, 0, 32'h0, rd, err, lat);
            chk("post_rst_latency", lat, 3);
            chk("post_rst_prdata", rd, 32'h0F0F_1234);
            chk("post_rst_pslverr", err, 0);
            check_dn("post_rst", 32'h1000, 0, 32'h0, 4'b0010);
            idle();
        end

`ifdef APB_DECODER_TIMEOUT_EN
        // Slave 2 hangs: the fabric gives up after TO stalled ACCESS cycles.
        hang[2] = 1;
        n0 = dacc_cycles;
        xfer(32'h2000, 0, 32'h0, rd, err, lat);
        chk("timeout_latency", lat, TO + 2);
        chk("timeout_pslverr", err, 1);
        chk("timeout_prdata", rd, 0);
        chk("timeout_access_cycles", dacc_cycles - n0, TO);
        chk("timeout_no_dn", dq.size(), 0);
        hang[2] = 0;
        idle();
`endif

        repeat (2) @(posedge PCLK);
        chk("psel_onehot_violations", oh_viol, 0);
        chk("pready_consecutive_violations", rdy_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d expected=finished", checks);
        $fatal(1, "bench timed out");
    end
endmodule
